// File: rtl/mux_lut_pkg.sv
// rtl/mux_lut_pkg.sv - shared truth-table constants and buffer sizing for mux_lut_pipe
package mux_lut_pkg;

    localparam logic [3:0] TT_AND    = 4'b1000;
    localparam logic [3:0] TT_OR     = 4'b1110;
    localparam logic [3:0] TT_XOR    = 4'b0110;
    localparam logic [3:0] TT_NAND   = 4'b0111;
    localparam logic [3:0] TT_PASS_A = 4'b1010;

    // Two-entry result buffer; occupancy needs to represent 0, 1 and 2.
    typedef logic [1:0] occ_t;
    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/lut2_bit.sv
// rtl/lut2_bit.sv - one bit of a 2-input LUT, tt[{b,a}], as a tree of three 2:1 muxes
module lut2_bit (
    input  logic [3:0] tt,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    logic lo;
    logic hi;

    // Inner level selects on a within each half of the table; outer level selects on b.
    mux2 u_mux_lo (.d0(tt[0]), .d1(tt[1]), .sel(a), .y(lo));
    mux2 u_mux_hi (.d0(tt[2]), .d1(tt[3]), .sel(a), .y(hi));
    mux2 u_mux_b  (.d0(lo),    .d1(hi),    .sel(b), .y(y));

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - single-bit 2:1 multiplexer
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_lut_pipe.sv
// rtl/mux_lut_pipe.sv - bitwise 2-input LUT with a 2-entry in-order result buffer and pop counter
module mux_lut_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       tt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] op_count
);

    import mux_lut_pkg::*;

    logic [WIDTH-1:0] lut_y;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        lut2_bit u_bit (
            .tt (tt),
            .a  (a[i]),
            .b  (b[i]),
            .y  (lut_y[i])
        );
    end

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    occ_t             occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    // in_ready is a flop so out_ready never reaches it combinationally.
    assign push = in_valid && in_ready_q;
    assign pop  = (occ_q != OCC_EMPTY) && out_ready;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        occ_d      = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = lut_y;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + CNT_W'(1);
        end
        occ_d      = occ_q + occ_t'(push) - occ_t'(pop);
        in_ready_d = (occ_d != OCC_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_data  = mem_q[rd_ptr_q];
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_mux_lut_pipe.sv
// tb/tb_mux_lut_pipe.sv - directed self-checking bench for mux_lut_pipe
module tb_mux_lut_pipe;

    import mux_lut_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, out_data;
    logic [3:0] tt;
    logic [3:0] op_count;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0]  a1, b1, out_data1;
    logic [3:0]  tt1;
    logic [15:0] op_count1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_lut_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .tt(tt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .op_count(op_count)
    );

    mux_lut_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .tt(tt1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .op_count(op_count1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tt;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic offer(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vtt);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        tt       = vtt;
    endtask

    initial begin
        logic [3:0] prev_cnt;
        logic       saw_wrap;
        logic [3:0] tv;
        logic [1:0] ab;
        logic       exp1;

        vecs[0] = '{8'hF0, 8'hCC, TT_AND,    8'hC0};
        vecs[1] = '{8'hF0, 8'hCC, TT_OR,     8'hFC};
        vecs[2] = '{8'hF0, 8'hCC, TT_XOR,    8'h3C};
        vecs[3] = '{8'hF0, 8'hCC, TT_NAND,   8'h3F};
        vecs[4] = '{8'h5A, 8'h33, TT_PASS_A, 8'h5A};
        vecs[5] = '{8'hA5, 8'h0F, 4'b0000,   8'h00};
        vecs[6] = '{8'h12, 8'h34, 4'b1111,   8'hFF};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; tt = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; tt1 = '0; out_ready1 = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);

        // Table: back-to-back operations with downstream always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            offer(vecs[k].a, vecs[k].b, vecs[k].tt);
            step();
            chk($sformatf("tbl_valid_%0d", k), 32'(out_valid), 1);
            chk($sformatf("tbl_data_%0d", k), 32'(out_data), 32'(vecs[k].exp));
            chk($sformatf("tbl_ready_%0d", k), 32'(in_ready), 1);
            chk($sformatf("tbl_cnt_%0d", k), 32'(op_count), 32'(k));
        end
        in_valid = 1'b0;
        step();
        chk("tbl_drain_valid", 32'(out_valid), 0);
        chk("tbl_drain_cnt", 32'(op_count), 7);

        // Stalled downstream: buffer fills after two, third is held off.
        out_ready = 1'b0;
        offer(8'h11, 8'h22, TT_XOR);
        step();
        chk("stall_ready1", 32'(in_ready), 1);
        chk("stall_data1", 32'(out_data), 32'h33);
        offer(8'h0F, 8'hFF, TT_AND);
        step();
        chk("stall_ready2", 32'(in_ready), 0);
        chk("stall_data2", 32'(out_data), 32'h33);
        offer(8'hAA, 8'h55, TT_OR);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall_hold_ready_%0d", k), 32'(in_ready), 0);
            chk($sformatf("stall_hold_valid_%0d", k), 32'(out_valid), 1);
            chk($sformatf("stall_hold_data_%0d", k), 32'(out_data), 32'h33);
            chk($sformatf("stall_hold_cnt_%0d", k), 32'(op_count), 7);
        end
        out_ready = 1'b1;
        step();
        chk("unstall_data", 32'(out_data), 32'h0F);
        chk("unstall_ready", 32'(in_ready), 1);
        chk("unstall_cnt", 32'(op_count), 8);
        step();
        chk("third_data", 32'(out_data), 32'hFF);
        chk("third_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        step();
        chk("stall_drain_valid", 32'(out_valid), 0);
        chk("stall_drain_cnt", 32'(op_count), 10);

        // Occupancy 1 with simultaneous push and pop for 10 cycles.
        offer(8'h00, 8'h5A, TT_XOR);
        step();
        chk("pp_prime_data", 32'(out_data), 32'h5A);
        for (int k = 1; k <= 10; k++) begin
            offer(8'(k * 7), 8'h5A, TT_XOR);
            step();
            chk($sformatf("pp_data_%0d", k), 32'(out_data), 32'(8'(k * 7) ^ 8'h5A));
            chk($sformatf("pp_valid_%0d", k), 32'(out_valid), 1);
            chk($sformatf("pp_ready_%0d", k), 32'(in_ready), 1);
        end
        chk("pp_cnt", 32'(op_count), 32'((10 + 10) % 16));
        in_valid = 1'b0;
        step();
        chk("pp_drain_valid", 32'(out_valid), 0);

        // Counter wrap on a 4-bit counter from a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("wrap_start_cnt", 32'(op_count), 0);
        saw_wrap = 1'b0;
        prev_cnt = op_count;
        for (int k = 1; k <= 17; k++) begin
            offer(8'(k), 8'h00, TT_PASS_A);
            step();
            if (prev_cnt == 4'd15 && op_count == 4'd0) saw_wrap = 1'b1;
            prev_cnt = op_count;
            chk($sformatf("wrap_cnt_%0d", k), 32'(op_count), 32'((k - 1) % 16));
        end
        in_valid = 1'b0;
        step();
        chk("wrap_end_cnt", 32'(op_count), 1);
        chk("wrap_seen", 32'(saw_wrap), 1);

        // Reset while the buffer is full.
        out_ready = 1'b0;
        offer(8'hDE, 8'hAD, TT_OR);
        step();
        offer(8'hBE, 8'hEF, TT_AND);
        step();
        chk("full_ready", 32'(in_ready), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        step();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_cnt", 32'(op_count), 0);
        chk("midrst_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        step();
        chk("midrst_after_ready", 32'(in_ready), 1);
        chk("midrst_after_valid", 32'(out_valid), 0);
        out_ready = 1'b0;
        offer(8'hC3, 8'h3C, TT_XOR);
        step();
        chk("postrst_valid", 32'(out_valid), 1);
        chk("postrst_data", 32'(out_data), 32'hFF);
        chk("postrst_cnt", 32'(op_count), 0);
        in_valid = 1'b0;

        // Exhaustive single-bit truth-table sweep on the WIDTH=1 instance.
        out_ready1 = 1'b1;
        chk("w1_ready", 32'(in_ready1), 1);
        for (int t = 0; t < 16; t++) begin
            for (int p = 0; p < 4; p++) begin
                tv = 4'(t);
                ab = 2'(p);
                exp1 = tv[ab];
                in_valid1 = 1'b1;
                tt1 = tv;
                a1  = ab[0];
                b1  = ab[1];
                step();
                chk($sformatf("w1_tt%0h_b%0d_a%0d", t, ab[1], ab[0]), 32'(out_data1), 32'(exp1));
            end
        end
        in_valid1 = 1'b0;
        step();
        chk("w1_cnt", 32'(op_count1), 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
